// File: rtl/conv_layer_stream.sv
// conv_layer_stream: sequential multi-channel convolution layer.
// One multiply-accumulate per cycle, bias preloaded into the accumulator,
// optional ReLU, saturation at the output, and pixels streamed row-major
// over a valid/ready handshake.
module conv_layer_stream #(
  parameter int    DATA_WIDTH  = 8,
  parameter int    KDATA_WIDTH = 8,
  parameter int    KERNEL_SIZE = 3,
  parameter int    IMGROW      = 7,
  parameter int    IMGCOL      = 7,
  parameter int    IN_CH       = 1,
  parameter int    STRIDE      = 1,
  parameter int    OUT_WIDTH   = 16,
  parameter string ACTIVATION  = "RELU"
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic signed [DATA_WIDTH-1:0]                    image  [IN_CH][IMGROW][IMGCOL],
  input  logic signed [KDATA_WIDTH-1:0]                   kernel [IN_CH][KERNEL_SIZE][KERNEL_SIZE],
  input  logic signed [DATA_WIDTH+KDATA_WIDTH-1:0]        bias,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic signed [OUT_WIDTH-1:0]                     out_data,
  output logic [$clog2((IMGROW-KERNEL_SIZE)/STRIDE+1):0]  out_row,
  output logic [$clog2((IMGCOL-KERNEL_SIZE)/STRIDE+1):0]  out_col,
  output logic                                            busy,
  output logic                                            layer_done_out
);

  localparam int OROW  = (IMGROW-KERNEL_SIZE)/STRIDE+1;
  localparam int OCOL  = (IMGCOL-KERNEL_SIZE)/STRIDE+1;
  localparam int N     = IN_CH*KERNEL_SIZE*KERNEL_SIZE;
  localparam int PW    = DATA_WIDTH+KDATA_WIDTH;
  localparam int ACC_W = PW+$clog2(N)+2;
  localparam int RW    = $clog2(OROW)+1;
  localparam int CW    = $clog2(OCOL)+1;
  localparam int RIW   = (IMGROW > 1) ? $clog2(IMGROW) : 1;
  localparam int CIW   = (IMGCOL > 1) ? $clog2(IMGCOL) : 1;
  localparam int CHW   = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int KIW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam bit USE_RELU = (ACTIVATION == "RELU");

  // Output clamp limits, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               state_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [RW-1:0]            orow_reg;
  logic [CW-1:0]            ocol_reg;
  logic [CHW-1:0]           c_reg;
  logic [KIW-1:0]           i_reg;
  logic [KIW-1:0]           j_reg;
  logic signed [OUT_WIDTH-1:0] out_data_reg;

  logic [RIW-1:0]           row_idx;
  logic [CIW-1:0]           col_idx;
  logic signed [DATA_WIDTH-1:0]  pix;
  logic signed [KDATA_WIDTH-1:0] coef;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  act_val;
  logic signed [ACC_W-1:0]  sat_val;
  logic signed [ACC_W-1:0]  bias_ext;
  logic                     last_tap;
  logic                     last_px;

  // Current tap: fetch sample and coefficient, form the next accumulator and its activated/clamped value.
  always_comb begin
    row_idx  = RIW'(int'(orow_reg)*STRIDE + int'(i_reg));
    col_idx  = CIW'(int'(ocol_reg)*STRIDE + int'(j_reg));
    pix      = image[c_reg][row_idx][col_idx];
    coef     = kernel[c_reg][i_reg][j_reg];
    prod     = pix * coef;
    acc_sum  = acc_reg + {{(ACC_W-PW){prod[PW-1]}}, prod};
    bias_ext = {{(ACC_W-PW){bias[PW-1]}}, bias};
    act_val  = (USE_RELU && acc_sum[ACC_W-1]) ? '0 : acc_sum;
    if (act_val > SAT_MAX)      sat_val = SAT_MAX;
    else if (act_val < SAT_MIN) sat_val = SAT_MIN;
    else                        sat_val = act_val;
    last_tap = (c_reg == CHW'(IN_CH-1)) && (i_reg == KIW'(KERNEL_SIZE-1)) &&
               (j_reg == KIW'(KERNEL_SIZE-1));
    last_px  = (orow_reg == RW'(OROW-1)) && (ocol_reg == CW'(OCOL-1));
  end

  // Layer sequencer: tap walk (channel, row, column), pixel walk and handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      acc_reg      <= '0;
      orow_reg     <= '0;
      ocol_reg     <= '0;
      c_reg        <= '0;
      i_reg        <= '0;
      j_reg        <= '0;
      out_data_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_MAC;
            acc_reg   <= bias_ext;
            orow_reg  <= '0;
            ocol_reg  <= '0;
            c_reg     <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
          end
        end
        S_MAC: begin
          acc_reg <= acc_sum;
          if (last_tap) begin
            state_reg    <= S_EMIT;
            out_data_reg <= sat_val[OUT_WIDTH-1:0];
            c_reg        <= '0;
            i_reg        <= '0;
            j_reg        <= '0;
          end else if (j_reg == KIW'(KERNEL_SIZE-1)) begin
            j_reg <= '0;
            if (i_reg == KIW'(KERNEL_SIZE-1)) begin
              i_reg <= '0;
              c_reg <= c_reg + 1'b1;
            end else begin
              i_reg <= i_reg + 1'b1;
            end
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (last_px) begin
              state_reg <= S_DONE;
              orow_reg  <= '0;
              ocol_reg  <= '0;
            end else begin
              state_reg <= S_MAC;
              acc_reg   <= bias_ext;
              if (ocol_reg == CW'(OCOL-1)) begin
                ocol_reg <= '0;
                orow_reg <= orow_reg + 1'b1;
              end else begin
                ocol_reg <= ocol_reg + 1'b1;
              end
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign out_valid      = (state_reg == S_EMIT);
  assign busy           = (state_reg == S_MAC) || (state_reg == S_EMIT);
  assign layer_done_out = (state_reg == S_DONE);
  assign out_data       = out_data_reg;
  assign out_row        = orow_reg;
  assign out_col        = ocol_reg;

endmodule

// File: tb/tb_conv_layer_stream.sv
// tb_conv_layer_stream: directed checks of conv_layer_stream across four
// parameterisations (default ReLU, identity, 8-bit saturating, 2-channel stride 2).
module tb_conv_layer_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, out_ready;
  logic start0, start1, start2, start3;
  logic signed [7:0]  img1  [1][7][7];
  logic signed [7:0]  kern1 [1][3][3];
  logic signed [7:0]  img2  [2][7][7];
  logic signed [7:0]  kern2 [2][3][3];
  logic signed [15:0] bias1, bias2;

  logic v0, v1, v2, v3, b0, b1, b2, b3, dn0, dn1, dn2, dn3;
  logic signed [15:0] d0, d1, d3;
  logic signed [7:0]  d2;
  logic [3:0] r0, c0, r1, c1, r2, c2;
  logic [2:0] r3, c3;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sel = 0;

  logic        v, bsy, dn;
  logic [31:0] d, r, c;

  conv_layer_stream u_def (.clk(clk), .rst(rst), .start(start0), .image(img1), .kernel(kern1),
    .bias(bias1), .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_row(r0),
    .out_col(c0), .busy(b0), .layer_done_out(dn0));

  conv_layer_stream #(.ACTIVATION("NONE")) u_none (.clk(clk), .rst(rst), .start(start1),
    .image(img1), .kernel(kern1), .bias(bias1), .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .out_row(r1), .out_col(c1), .busy(b1), .layer_done_out(dn1));

  conv_layer_stream #(.OUT_WIDTH(8), .ACTIVATION("NONE")) u_sat (.clk(clk), .rst(rst),
    .start(start2), .image(img1), .kernel(kern1), .bias(bias1), .out_valid(v2),
    .out_ready(out_ready), .out_data(d2), .out_row(r2), .out_col(c2), .busy(b2),
    .layer_done_out(dn2));

  conv_layer_stream #(.IN_CH(2), .STRIDE(2)) u_ch2 (.clk(clk), .rst(rst), .start(start3),
    .image(img2), .kernel(kern2), .bias(bias2), .out_valid(v3), .out_ready(out_ready),
    .out_data(d3), .out_row(r3), .out_col(c3), .busy(b3), .layer_done_out(dn3));

  // Route the selected instance onto common observation signals.
  always_comb begin
    v = v0; bsy = b0; dn = dn0;
    d = {{16{d0[15]}}, d0};
    r = 32'(r0); c = 32'(c0);
    case (sel)
      1: begin v = v1; bsy = b1; dn = dn1; d = {{16{d1[15]}}, d1}; r = 32'(r1); c = 32'(c1); end
      2: begin v = v2; bsy = b2; dn = dn2; d = {{24{d2[7]}}, d2};  r = 32'(r2); c = 32'(c2); end
      3: begin v = v3; bsy = b3; dn = dn3; d = {{16{d3[15]}}, d3}; r = 32'(r3); c = 32'(c3); end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_start(input int s, input logic val);
    case (s)
      0: start0 = val;
      1: start1 = val;
      2: start2 = val;
      default: start3 = val;
    endcase
  endtask

  task automatic fill1(input int ival, input int kval);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++) img1[0][i][j] = 8'(ival);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) kern1[0][i][j] = 8'(kval);
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!v && n < 400) begin
      step();
      n++;
    end
    ok = v;
    if (!ok) check("valid_timeout", 32'(v), 32'd1);
  endtask

  // Start a layer on instance s and check every pixel (time, value, coordinate) and the done pulse.
  task automatic run_layer(input int s, input int npix, input int ncol, input int expv,
                           input int per, input bit glitch);
    bit ok;
    sel = s;
    cyc = 0;
    set_start(s, 1'b1);
    step();
    set_start(s, 1'b0);
    if (glitch) begin
      step();
      check("busy_c2", 32'(bsy), 32'd1);
      set_start(s, 1'b1);
      step();
      set_start(s, 1'b0);
    end
    for (int p = 0; p < npix; p++) begin
      wait_valid(ok);
      if (!ok) return;
      check("px_cycle", cyc, (p+1)*per);
      check("px_data", d, expv);
      check("px_row", r, p/ncol);
      check("px_col", c, p%ncol);
      check("px_busy", 32'(bsy), 32'd1);
      step();
    end
    check("done_cycle", cyc, npix*per+1);
    check("done_pulse", 32'(dn), 32'd1);
    check("done_busy", 32'(bsy), 32'd0);
    step();
    check("done_low", 32'(dn), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(v), 32'd0);
    check({tag, "_data"}, d, 32'd0);
    check({tag, "_row"}, r, 32'd0);
    check({tag, "_col"}, c, 32'd0);
    check({tag, "_busy"}, 32'(bsy), 32'd0);
    check({tag, "_done"}, 32'(dn), 32'd0);
  endtask

  initial begin
    bit ok;
    int h;
    rst = 1'b0; out_ready = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    bias1 = 16'sd0; bias2 = 16'sd3;
    fill1(1, 1);
    for (int ch = 0; ch < 2; ch++) begin
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 7; j++) img2[ch][i][j] = 8'(ch + 1);
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) kern2[ch][i][j] = 8'sd1;
    end
    step(); step();
    sel = 0;
    check_zero("reset");
    rst = 1'b1;
    step();

    // All ones: 25 pixels of 9
    run_layer(0, 25, 5, 9, 10, 1'b0);
    $display("layer all-ones relu done: total=%0d", total);

    // Kernel -1: ReLU floors at 0, identity gives -9
    fill1(1, -1);
    run_layer(0, 25, 5, 0, 10, 1'b0);
    $display("layer kernel -1 relu done: total=%0d", total);
    run_layer(1, 25, 5, -9, 10, 1'b0);
    $display("layer kernel -1 none done: total=%0d", total);

    // 8-bit output saturation
    fill1(127, 127);
    run_layer(2, 25, 5, 127, 10, 1'b0);
    $display("layer saturate high done: total=%0d", total);
    fill1(127, -128);
    run_layer(2, 25, 5, -128, 10, 1'b0);
    $display("layer saturate low done: total=%0d", total);

    // Backpressure on the first pixel, then reset in the third pixel's MAC
    fill1(1, 1);
    sel = 0;
    cyc = 0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    wait_valid(ok);
    check("bp_first_cycle", cyc, 10);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 32'(v), 32'd1);
      check("bp_data", d, 32'd9);
      check("bp_row", r, 32'd0);
      check("bp_col", c, 32'd0);
      check("bp_busy", 32'(bsy), 32'd1);
    end
    out_ready = 1'b1;
    h = cyc;
    step();
    check("bp_mac_busy", 32'(bsy), 32'd1);
    wait_valid(ok);
    check("bp_second_cycle", cyc, h + 10);
    check("bp_second_data", d, 32'd9);
    check("bp_second_col", c, 32'd1);
    step();
    step(); step(); step();
    check("mid_mac_busy", 32'(bsy), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_zero("midrst");
    step();
    $display("backpressure and mid-layer reset done: total=%0d", total);

    // Fresh start with an ignored start pulse while busy
    run_layer(0, 25, 5, 9, 10, 1'b1);
    $display("layer restart done: total=%0d", total);

    // Two channels, stride 2, bias 3: 9 + 18 + 3 = 30, N = 18
    run_layer(3, 9, 3, 30, 19, 1'b0);
    $display("layer two-channel stride-2 done: total=%0d", total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
